// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// Valid/ready on both sides, sticky overflow and a leading-zero blanking mask.
module bcd_seq_converter #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int BLANK_EN = 1
) (
    input  logic                  clk,
    input  logic                  btn_reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank_mask,
    output logic                  overflow
);

    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_bin;
    logic [DW-1:0]     r_bcd;
    logic              r_ovf;
    logic [CW-1:0]     r_cnt;
    logic [DW-1:0]     w_adj;
    logic [DW-1:0]     w_bcd_sh;
    logic              w_carry;
    logic              w_last;
    logic              w_ovf_nxt;

    function automatic logic [DW-1:0] add3(input logic [DW-1:0] bcd);
        logic [DW-1:0] res;
        res = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return res;
    endfunction

    // Digit i (i>=1) is blank when it and every digit above it are zero; units never blank.
    function automatic logic [DIGITS-1:0] blank_of(input logic [DW-1:0] bcd, input logic ovf);
        logic [DIGITS-1:0] m;
        logic              zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (bcd[4*i +: 4] == 4'd0);
            m[i]       = zero_above;
        end
        return (ovf || (BLANK_EN == 0)) ? '0 : m;
    endfunction

    always_comb begin
        w_adj     = add3(r_bcd);
        w_bcd_sh  = {w_adj[DW-2:0], r_bin[WIDTH-1]};
        w_carry   = w_adj[DW-1];
        w_last    = (r_cnt == CW'(1));
        w_ovf_nxt = r_ovf | w_carry;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they track the FSM without a comb path.
    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            r_state   <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            in_ready  <= (w_state_nxt == ST_IDLE);
            out_valid <= (w_state_nxt == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
            r_cnt      <= '0;
            bcd_out    <= '0;
            blank_mask <= '0;
            overflow   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_bin <= bin_in;
                        r_bcd <= '0;
                        r_ovf <= 1'b0;
                        r_cnt <= CW'(WIDTH);
                    end
                end
                ST_SHIFT: begin
                    r_bin <= r_bin << 1'b1;
                    r_bcd <= w_bcd_sh;
                    r_ovf <= w_ovf_nxt;
                    r_cnt <= r_cnt - CW'(1);
                    // Result registers load only on the final shift, so partial values never appear.
                    if (w_last) begin
                        bcd_out    <= w_bcd_sh;
                        overflow   <= w_ovf_nxt;
                        blank_mask <= blank_of(w_bcd_sh, w_ovf_nxt);
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Randomized self-checking bench: three converter configurations (W8/D3, W8/D2, W16/D5)
// compared against an arithmetic decimal model.
module tb_bcd_seq_converter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  iv;
    logic [2:0]  ordy;
    logic [7:0]  b0, b1;
    logic [15:0] b2;
    logic [2:0]  ir, ov, of;
    logic [11:0] bcd0;
    logic [7:0]  bcd1;
    logic [19:0] bcd2;
    logic [2:0]  m0;
    logic [1:0]  m1;
    logic [4:0]  m2;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    int wid [3] = '{8, 8, 16};
    int dig [3] = '{3, 2, 5};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    bcd_seq_converter #(.WIDTH(8), .DIGITS(3), .BLANK_EN(1)) u0 (
        .clk(clk), .btn_reset(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .bin_in(b0),
        .out_valid(ov[0]), .out_ready(ordy[0]), .bcd_out(bcd0), .blank_mask(m0), .overflow(of[0]));
    bcd_seq_converter #(.WIDTH(8), .DIGITS(2), .BLANK_EN(1)) u1 (
        .clk(clk), .btn_reset(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .bin_in(b1),
        .out_valid(ov[1]), .out_ready(ordy[1]), .bcd_out(bcd1), .blank_mask(m1), .overflow(of[1]));
    bcd_seq_converter #(.WIDTH(16), .DIGITS(5), .BLANK_EN(1)) u2 (
        .clk(clk), .btn_reset(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .bin_in(b2),
        .out_valid(ov[2]), .out_ready(ordy[2]), .bcd_out(bcd2), .blank_mask(m2), .overflow(of[2]));

    // Decimal reference: value mod 10**d split into digits; digit i blank iff value < 10**i.
    function automatic void model(input int d, input longint v, output logic [19:0] bcd,
                                  output logic [4:0] m, output logic o);
        longint lim = 1;
        longint r;
        longint p;
        for (int i = 0; i < d; i++) lim = lim * 10;
        o   = (v >= lim);
        r   = v % lim;
        bcd = '0;
        for (int i = 0; i < d; i++) begin
            bcd[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        m = '0;
        p = 10;
        if (!o) begin
            for (int i = 1; i < d; i++) begin
                m[i] = (v < p);
                p = p * 10;
            end
        end
    endfunction

    task automatic sample(input int k, output logic [19:0] bcd, output logic [4:0] m,
                          output logic o, output logic vld, output logic rdy);
        case (k)
            0: begin bcd = {8'd0, bcd0};  m = {2'd0, m0}; end
            1: begin bcd = {12'd0, bcd1}; m = {3'd0, m1}; end
            default: begin bcd = bcd2; m = m2; end
        endcase
        o   = of[k];
        vld = ov[k];
        rdy = ir[k];
    endtask

    task automatic drive_bin(input int k, input longint v);
        case (k)
            0: b0 = v[7:0];
            1: b1 = v[7:0];
            default: b2 = v[15:0];
        endcase
    endtask

    task automatic check_reset_outputs(input int k, input string nm);
        logic [19:0] bcd; logic [4:0] m; logic o, vld, rdy;
        sample(k, bcd, m, o, vld, rdy);
        vectors++;
        if ({rdy, vld, o, m, bcd} !== {1'b1, 1'b0, 1'b0, 5'd0, 20'd0}) begin
            miscompares++;
            $display("FAIL %s dut%0d: rdy=%b vld=%b ovf=%b mask=%b bcd=%h, expected 1 0 0 0 0",
                     nm, k, rdy, vld, o, m, bcd);
        end
    endtask

    // One full transaction: accept, count latency, check result, optional backpressure, release.
    task automatic convert(input int k, input longint v, input int hold, input string nm);
        logic [19:0] bcd, ebcd, held; logic [4:0] m, em; logic o, eo, vld, rdy;
        int n = 0;
        int lat = 0;
        sample(k, bcd, m, o, vld, rdy);
        while (!rdy && n < 50) begin
            @(posedge clk); #1; n++;
            sample(k, bcd, m, o, vld, rdy);
        end
        vectors++;
        if (!rdy) begin
            miscompares++;
            $display("FAIL %s ready_wait dut%0d: in_ready=%b, expected 1", nm, k, rdy);
        end
        drive_bin(k, v);
        iv[k] = 1'b1;
        @(posedge clk); #1;
        sample(k, bcd, m, o, vld, rdy);
        while (!vld && lat < 100) begin
            iv[k] = 1'b1;
            drive_bin(k, longint'($urandom));
            @(posedge clk); #1; lat++;
            sample(k, bcd, m, o, vld, rdy);
        end
        iv[k] = 1'b0;
        model(dig[k], v, ebcd, em, eo);
        vectors++;
        if (lat !== wid[k]) begin
            miscompares++;
            $display("FAIL %s latency dut%0d v=%0d: got %0d edges, expected %0d", nm, k, v, lat, wid[k]);
        end
        vectors++;
        if ({bcd, m, o, rdy} !== {ebcd, em, eo, 1'b0}) begin
            miscompares++;
            $display("FAIL %s result dut%0d v=%0d: bcd=%h mask=%b ovf=%b rdy=%b, expected %h %b %b 0",
                     nm, k, v, bcd, m, o, rdy, ebcd, em, eo);
        end
        held = bcd;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            sample(k, bcd, m, o, vld, rdy);
            vectors++;
            if ({vld, rdy, bcd} !== {1'b1, 1'b0, held}) begin
                miscompares++;
                $display("FAIL %s hold dut%0d cyc%0d: vld=%b rdy=%b bcd=%h, expected 1 0 %h",
                         nm, k, h, vld, rdy, bcd, held);
            end
        end
        ordy[k] = 1'b1;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
        sample(k, bcd, m, o, vld, rdy);
        vectors++;
        if ({vld, rdy} !== 2'b01) begin
            miscompares++;
            $display("FAIL %s release dut%0d: vld=%b rdy=%b, expected 0 1", nm, k, vld, rdy);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) check_reset_outputs(k, "reset");
    endtask

    task automatic test_boundaries();
        convert(0, 255, 0, "w8d3_max");
        convert(0, 7, 0, "w8d3_seven");
        convert(0, 0, 0, "w8d3_zero");
        convert(1, 255, 0, "w8d2_ovf");
        convert(1, 99, 0, "w8d2_99");
        convert(1, 100, 0, "w8d2_100");
        convert(1, 0, 0, "w8d2_zero");
        convert(2, 65535, 0, "w16d5_max");
        convert(2, 0, 0, "w16d5_zero");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            convert(0, longint'($urandom_range(0, 255)), 0, "rand_w8d3");
            convert(1, longint'($urandom_range(0, 255)), 0, "rand_w8d2");
            convert(2, longint'($urandom_range(0, 65535)), 0, "rand_w16d5");
        end
    endtask

    task automatic test_backpressure();
        convert(0, longint'($urandom_range(100, 255)), 20, "backpressure");
    endtask

    task automatic test_reset_mid_shift();
        drive_bin(0, 200);
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs(0, "reset_mid_shift");
        #2 rst_n = 1'b1;
        convert(0, 128, 0, "after_reset_128");
    endtask

    task automatic test_back_to_back();
        longint vals [3] = '{65535, 1000, 9};
        int acc [3];
        logic [19:0] bcd, ebcd; logic [4:0] m, em; logic o, eo, vld, rdy;
        int n;
        ordy[2] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            n = 0;
            sample(2, bcd, m, o, vld, rdy);
            while (!rdy && n < 50) begin
                @(posedge clk); #1; n++;
                sample(2, bcd, m, o, vld, rdy);
            end
            drive_bin(2, vals[j]);
            iv[2] = 1'b1;
            @(posedge clk); #1;
            acc[j] = cyc;
            iv[2] = 1'b0;
            n = 0;
            sample(2, bcd, m, o, vld, rdy);
            while (!vld && n < 100) begin
                @(posedge clk); #1; n++;
                sample(2, bcd, m, o, vld, rdy);
            end
            model(5, vals[j], ebcd, em, eo);
            vectors++;
            if ({vld, bcd, o} !== {1'b1, ebcd, eo}) begin
                miscompares++;
                $display("FAIL b2b result %0d: vld=%b bcd=%h ovf=%b, expected 1 %h %b", j, vld, bcd, o, ebcd, eo);
            end
            if (j > 0) begin
                vectors++;
                if (acc[j] - acc[j-1] !== 18) begin
                    miscompares++;
                    $display("FAIL b2b spacing %0d: got %0d cycles, expected 18", j, acc[j] - acc[j-1]);
                end
            end
        end
        @(posedge clk); #1;
        ordy[2] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        iv    = '0;
        ordy  = '0;
        b0    = '0;
        b1    = '0;
        b2    = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_boundaries();
        test_random();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
